ysyx_2022040010_mem_arbiter_n: RTL and testbench
================================================

// Module: ysyx_2022040010_mem_arbiter_n
// PURPOSE
//  N-channel request arbiter in front of the single-outstanding AXI rw bridge (axi_rw).
//  Successor of the fixed 3-port icache/dcache/uncache arbiter.
//  Channel count, address width and data width are parameters; fixed-priority or round-robin mode is selectable.
//  Adds per-transaction ID tagging/checking and an error flag. One transaction in flight at a time.
// PARAMETERS
//  N_CH     3    number of requesters, 2..8; channel 0 = lowest index
//  AW       64   address width
//  DW       64   data width, multiple of 8
//  ID_W     4    rw id width; 2**ID_W >= N_CH
//  RR_MODE  1    0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clock          in   1          system clock
//  reset          in   1          synchronous, active-high
//  req_valid_i    in   N_CH       per-channel request; held until its resp_done_o
//  req_we_i       in   N_CH       1 = write, 0 = read
//  req_addr_i     in   N_CH*AW    channel k at [k*AW +: AW]
//  req_wdata_i    in   N_CH*DW    channel k at [k*DW +: DW]
//  req_mask_i     in   N_CH*DW/8  byte strobes, channel k at [k*DW/8 +: DW/8]
//  req_size_i     in   N_CH*2     transfer size code, channel k at [k*2 +: 2]
//  resp_data_o    out  DW         read data, valid while resp_done_o != 0
//  resp_done_o    out  N_CH       one-hot completion pulse for the granted channel
//  resp_err_o     out  1          valid with resp_done_o: bad resp or id mismatch
//  rw_valid_o     out  1          request to bridge
//  rw_ready_i     in   1          bridge completion pulse
//  rw_req_o       out  1          0 = read, 1 = write
//  rw_addr_o      out  AW         latched address
//  rw_size_o      out  2          latched size
//  data_write_o   out  DW         latched write data
//  w_mask_o       out  DW/8       latched strobes
//  rw_id_o        out  ID_W       granted channel index, zero-extended
//  data_read_i    in   DW         bridge read data, valid with rw_ready_i
//  rw_resp_i      in   2          bridge response, 0 = OKAY
//  rw_id_i        in   ID_W       returned id
// BEHAVIOUR
//  - FSM states: IDLE -> ISSUE -> DONE -> IDLE.
//  - Reset: state = IDLE, rr_ptr = N_CH-1, all outputs 0, latches cleared.
//  - IDLE:
//    - If any req_valid_i is set, select the winner.
//      - Fixed mode: lowest set index.
//      - RR mode: first set index searching upward from rr_ptr+1, wrapping modulo N_CH.
//    - Latch the winner's we, addr, wdata, mask and size; grant = index.
//    - RR mode: rr_ptr = winner. Then go to ISSUE.
//  - ISSUE:
//    - rw_valid_o = 1. All rw_* outputs are stable from latches for the whole state.
//    - Stay until rw_ready_i = 1.
//    - On rw_ready_i: capture data_read_i; err = (rw_resp_i != 0) | (rw_id_i != grant). Go to DONE.
//  - DONE (exactly 1 cycle):
//    - rw_valid_o = 0.
//    - resp_done_o = 1 << grant; resp_data_o = captured data (writes return 0); resp_err_o = err.
//    - No arbitration in this state. Go to IDLE.
//  - Outside DONE: resp_done_o = 0, resp_err_o = 0, resp_data_o holds its last value.
//  - Latency, request seen in IDLE at cycle t with bridge ready at t+1+L:
//    - rw_valid_o high at t+1;
//    - resp_done_o at t+2+L;
//    - earliest next grant sampled at t+3+L.
//  - Requester rules:
//    - Keep req_valid_i and its payload stable until done.
//    - Deassert the cycle after done.
//    - A still-high valid in IDLE is treated as a new request.
//  - Non-granted channels' inputs are ignored while busy; a request changing while not granted is legal.
//  - rw_ready_i outside ISSUE is ignored (no state change, no err).
//  - Single requester: granted every time regardless of mode.
//  - RR wrap: with rr_ptr = N_CH-1 the search starts at 0.
//  - Reset mid-transaction: abandon immediately, no done pulse. The bridge is reset in the same cycle.
// TESTING
//  1. N_CH=3, RR=1: read on ch1, addr 0x8000_0010, bridge ready 4 cycles later with data 0xDEAD_BEEF_0123_4567, resp 0
//     -> rw_id_o=1, rw_req_o=0, resp_done_o=3'b010 one cycle, data matches, err=0.
//  2. Round-robin: ch0, ch1, ch2 all requesting continuously -> grant order 0,1,2,0,1,2; fixed mode (RR=0) -> 0,0,0.
//  3. Write on ch2: wdata 0x1122_3344_5566_7788, mask 8'h0F, size 2
//     -> rw_req_o=1, w_mask_o=8'h0F, data_write_o/rw_size_o match, resp_done_o=3'b100.
//  4. Error: rw_resp_i=2'b10 -> resp_err_o=1 with done. Separately rw_id_i=3 while grant=0 -> resp_err_o=1.
//  5. Reset asserted in ISSUE -> next cycle rw_valid_o=0, resp_done_o=0, state IDLE, ch0 granted first after release.
//  6. Spurious rw_ready_i pulse in IDLE with no request -> no done, no state change; ready held low 200 cycles in ISSUE
//     -> rw_valid_o stays 1, latched outputs stable.

Source files
------------

// File: rtl/ysyx_2022040010_mem_arbiter_n.sv
// N-channel request arbiter in front of a single-outstanding AXI rw bridge.
// Fixed-priority or round-robin grant, id tagging on the rw channel and a per-transaction error flag.
module ysyx_2022040010_mem_arbiter_n #(
   parameter int unsigned N_CH    = 3,
   parameter int unsigned AW      = 64,
   parameter int unsigned DW      = 64,
   parameter int unsigned ID_W    = 4,
   parameter int unsigned RR_MODE = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_CH-1:0]        req_valid_i,
   input  logic [N_CH-1:0]        req_we_i,
   input  logic [N_CH*AW-1:0]     req_addr_i,
   input  logic [N_CH*DW-1:0]     req_wdata_i,
   input  logic [N_CH*DW/8-1:0]   req_mask_i,
   input  logic [N_CH*2-1:0]      req_size_i,
   output logic [DW-1:0]          resp_data_o,
   output logic [N_CH-1:0]        resp_done_o,
   output logic                   resp_err_o,
   output logic                   rw_valid_o,
   input  logic                   rw_ready_i,
   output logic                   rw_req_o,
   output logic [AW-1:0]          rw_addr_o,
   output logic [1:0]             rw_size_o,
   output logic [DW-1:0]          data_write_o,
   output logic [DW/8-1:0]        w_mask_o,
   output logic [ID_W-1:0]        rw_id_o,
   input  logic [DW-1:0]          data_read_i,
   input  logic [1:0]             rw_resp_i,
   input  logic [ID_W-1:0]        rw_id_i
);

   localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned MW = DW / 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    r_state;
   logic [PW-1:0] r_rr_ptr;
   logic [PW-1:0] r_grant;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [MW-1:0] r_mask;
   logic [1:0]    r_size;
   logic [DW-1:0] r_rdata;
   logic          r_err;

   logic          w_found;
   logic [PW-1:0] w_win;
   logic [PW-1:0] w_idx;
   int unsigned   w_sum;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic [MW-1:0] w_mask;
   logic [1:0]    w_size;

   // Winner search: in RR mode scan upward from rr_ptr+1 with wrap, else from channel 0.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = 0;
      w_idx   = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         w_sum = (RR_MODE != 0) ? ((32'(r_rr_ptr) + i + 32'd1) % N_CH) : i;
         w_idx = PW'(w_sum);
         if (!w_found && req_valid_i[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_we    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      w_mask  = '0;
      w_size  = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (w_win == PW'(k)) begin
            w_we    = req_we_i[k];
            w_addr  = req_addr_i[k*AW +: AW];
            w_wdata = req_wdata_i[k*DW +: DW];
            w_mask  = req_mask_i[k*MW +: MW];
            w_size  = req_size_i[k*2 +: 2];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= PW'(N_CH - 1);
         r_grant  <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_mask   <= '0;
         r_size   <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_we    <= w_we;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_mask  <= w_mask;
                  r_size  <= w_size;
                  r_grant <= w_win;
                  if (RR_MODE != 0) r_rr_ptr <= w_win;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (rw_ready_i) begin
                  r_rdata <= r_we ? '0 : data_read_i;
                  r_err   <= (rw_resp_i != 2'b00) | (rw_id_i != ID_W'(r_grant));
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      resp_done_o = '0;
      if (r_state == S_DONE) resp_done_o[r_grant] = 1'b1;
   end

   // resp_data_o is left holding the last completion outside DONE.
   assign resp_data_o  = r_rdata;
   assign resp_err_o   = (r_state == S_DONE) & r_err;
   assign rw_valid_o   = (r_state == S_ISSUE);
   assign rw_req_o     = r_we;
   assign rw_addr_o    = r_addr;
   assign rw_size_o    = r_size;
   assign data_write_o = r_wdata;
   assign w_mask_o     = r_mask;
   assign rw_id_o      = ID_W'(r_grant);

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter_n.sv
// Scoreboard bench for the N-channel arbiter: round-robin DUT checked on every completion,
// a fixed-priority twin on the same stimulus checked for its grant order.
module tb_ysyx_2022040010_mem_arbiter_n;

   typedef struct packed {
      logic [2:0]  done;
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset;
   logic [2:0]   req_valid, req_we;
   logic [191:0] req_addr, req_wdata;
   logic [23:0]  req_mask;
   logic [5:0]   req_size;
   logic         rw_ready;
   logic [63:0]  data_read;
   logic [1:0]   rw_resp;
   logic [3:0]   rw_id_in;

   logic [63:0]  resp_data, rw_addr, data_write;
   logic [2:0]   resp_done;
   logic         resp_err, rw_valid, rw_req;
   logic [1:0]   rw_size;
   logic [7:0]   w_mask;
   logic [3:0]   rw_id;

   logic [63:0]  fx_resp_data, fx_rw_addr, fx_data_write;
   logic [2:0]   fx_resp_done;
   logic         fx_resp_err, fx_rw_valid, fx_rw_req;
   logic [1:0]   fx_rw_size;
   logic [7:0]   fx_w_mask;
   logic [3:0]   fx_rw_id;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clock = ~clock;

   ysyx_2022040010_mem_arbiter_n #(.N_CH(3), .AW(64), .DW(64), .ID_W(4), .RR_MODE(1)) u_dut (
      .clock(clock), .reset(reset),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_mask_i(req_mask), .req_size_i(req_size),
      .resp_data_o(resp_data), .resp_done_o(resp_done), .resp_err_o(resp_err),
      .rw_valid_o(rw_valid), .rw_ready_i(rw_ready), .rw_req_o(rw_req),
      .rw_addr_o(rw_addr), .rw_size_o(rw_size), .data_write_o(data_write),
      .w_mask_o(w_mask), .rw_id_o(rw_id), .data_read_i(data_read),
      .rw_resp_i(rw_resp), .rw_id_i(rw_id_in)
   );

   ysyx_2022040010_mem_arbiter_n #(.N_CH(3), .AW(64), .DW(64), .ID_W(4), .RR_MODE(0)) u_dut_fx (
      .clock(clock), .reset(reset),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_mask_i(req_mask), .req_size_i(req_size),
      .resp_data_o(fx_resp_data), .resp_done_o(fx_resp_done), .resp_err_o(fx_resp_err),
      .rw_valid_o(fx_rw_valid), .rw_ready_i(rw_ready), .rw_req_o(fx_rw_req),
      .rw_addr_o(fx_rw_addr), .rw_size_o(fx_rw_size), .data_write_o(fx_data_write),
      .w_mask_o(fx_w_mask), .rw_id_o(fx_rw_id), .data_read_i(data_read),
      .rw_resp_i(rw_resp), .rw_id_i(rw_id_in)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every completion pulse pops one expected response.
   always @(negedge clock) begin
      if (reset === 1'b0 && resp_done !== 3'b000) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got %b expected no completion", resp_done);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_done", 64'(resp_done), 64'(mon_e.done));
            chk("sb_data", resp_data, mon_e.data);
            chk("sb_err", 64'(resp_err), 64'(mon_e.err));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int ch, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] mask, input logic [1:0] size);
      req_we[ch]             = we;
      req_addr[ch*64 +: 64]  = addr;
      req_wdata[ch*64 +: 64] = wdata;
      req_mask[ch*8 +: 8]    = mask;
      req_size[ch*2 +: 2]    = size;
      req_valid[ch]          = 1'b1;
   endtask

   task automatic push_exp(input int ch, input logic [63:0] data, input logic err);
      exp_t e;
      e.done = 3'b001 << ch;
      e.data = data;
      e.err  = err;
      sb.push_back(e);
   endtask

   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (rw_valid === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n < 0) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: rw_valid_o=0 after 20 cycles, required 1");
      end
   endtask

   // Bridge completes lat cycles into ISSUE; returns positioned in the DONE cycle.
   task automatic bridge(input int lat, input logic [63:0] data, input logic [1:0] resp,
                         input logic [3:0] id);
      repeat (lat - 1) step();
      rw_ready  = 1'b1;
      data_read = data;
      rw_resp   = resp;
      rw_id_in  = id;
      step();
      rw_ready  = 1'b0;
      rw_resp   = 2'b00;
   endtask

   task automatic txn(input int ch, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] mask, input logic [1:0] size,
                      input int lat, input logic [63:0] rdata, input logic [1:0] resp,
                      input logic [3:0] id, input logic exp_err, input logic [63:0] exp_data);
      int n;
      set_req(ch, we, addr, wdata, mask, size);
      push_exp(ch, exp_data, exp_err);
      wait_valid(n);
      chk("issue_latency", 64'(n), 64'd1);
      chk("grant_id", 64'(rw_id), 64'(ch));
      chk("rw_req", 64'(rw_req), 64'(we));
      chk("rw_addr", rw_addr, addr);
      chk("data_write", data_write, wdata);
      chk("w_mask", 64'(w_mask), 64'(mask));
      chk("rw_size", 64'(rw_size), 64'(size));
      bridge(lat, rdata, resp, id);
      chk("done_pulse", 64'(resp_done), 64'd1 << ch);
      chk("issue_drop", 64'(rw_valid), 64'd0);
      req_valid[ch] = 1'b0;
      step();
      chk("done_clear", 64'(resp_done), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int n;
      int k;
      int bad;
      reset     = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_mask  = '0;
      req_size  = '0;
      rw_ready  = 1'b0;
      data_read = '0;
      rw_resp   = '0;
      rw_id_in  = '0;
      repeat (2) step();
      chk("rst_valid", 64'(rw_valid), 64'd0);
      chk("rst_done", 64'(resp_done), 64'd0);
      chk("rst_err", 64'(resp_err), 64'd0);
      chk("rst_data", resp_data, 64'd0);
      chk("rst_addr", rw_addr, 64'd0);
      reset = 1'b0;
      step();

      // Spurious bridge completion while idle.
      rw_ready = 1'b1;
      rw_resp  = 2'b10;
      data_read = 64'hFFFF_0000_FFFF_0000;
      step();
      rw_ready = 1'b0;
      rw_resp  = 2'b00;
      repeat (3) begin
         step();
         chk("spur_valid", 64'(rw_valid), 64'd0);
         chk("spur_done", 64'(resp_done), 64'd0);
      end

      // All three requesting continuously: RR gives 0,1,2,0,1,2; fixed gives 0 every time.
      for (int c = 0; c < 3; c++) set_req(c, 1'b0, 64'h1000 + 64'(c) * 64'h100, 64'd0, 8'h00, 2'd3);
      for (int t = 0; t < 6; t++) begin
         k = t % 3;
         push_exp(k, 64'hA0 + 64'(t), 1'b0);
         wait_valid(n);
         chk("rr_grant", 64'(rw_id), 64'(k));
         chk("fx_grant", 64'(fx_rw_id), 64'd0);
         chk("rr_addr", rw_addr, 64'h1000 + 64'(k) * 64'h100);
         bridge(1, 64'hA0 + 64'(t), 2'b00, 4'(k));
      end
      req_valid = '0;
      step();

      txn(1, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 2'd3, 4, 64'hDEAD_BEEF_0123_4567, 2'b00, 4'd1,
          1'b0, 64'hDEAD_BEEF_0123_4567);
      txn(2, 1'b1, 64'h8000_0100, 64'h1122_3344_5566_7788, 8'h0F, 2'd2, 2, 64'hCAFE_CAFE_CAFE_CAFE,
          2'b00, 4'd2, 1'b0, 64'd0);
      txn(0, 1'b0, 64'h8000_0200, 64'd0, 8'h00, 2'd3, 1, 64'h0000_0000_0000_1234, 2'b10, 4'd0,
          1'b1, 64'h0000_0000_0000_1234);
      txn(0, 1'b0, 64'h8000_0208, 64'd0, 8'h00, 2'd3, 3, 64'h0000_0000_0000_5678, 2'b00, 4'd3,
          1'b1, 64'h0000_0000_0000_5678);

      // Reset in ISSUE abandons the transaction without a completion.
      set_req(2, 1'b0, 64'h9000_0000, 64'd0, 8'h00, 2'd3);
      wait_valid(n);
      chk("pre_rst_grant", 64'(rw_id), 64'd2);
      reset = 1'b1;
      set_req(0, 1'b0, 64'h9000_0040, 64'd0, 8'h00, 2'd3);
      step();
      chk("mid_rst_valid", 64'(rw_valid), 64'd0);
      chk("mid_rst_done", 64'(resp_done), 64'd0);
      chk("mid_rst_data", resp_data, 64'd0);
      reset = 1'b0;
      push_exp(0, 64'h0BAD_F00D, 1'b0);
      wait_valid(n);
      chk("post_rst_grant", 64'(rw_id), 64'd0);
      chk("post_rst_addr", rw_addr, 64'h9000_0040);
      bridge(2, 64'h0BAD_F00D, 2'b00, 4'd0);
      req_valid = '0;
      step();

      // Bridge stalls 200 cycles; a competing request mid-stall must not disturb the latches.
      set_req(1, 1'b0, 64'h0000_2468, 64'd0, 8'h00, 2'd1);
      push_exp(1, 64'h55, 1'b0);
      wait_valid(n);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (i == 100) set_req(0, 1'b1, 64'h0000_1357, 64'h77, 8'hFF, 2'd3);
         step();
         if (rw_valid !== 1'b1 || rw_addr !== 64'h0000_2468 || rw_id !== 4'd1 ||
             rw_req !== 1'b0 || rw_size !== 2'd1)
            bad++;
      end
      chk("stall_stable", 64'(bad), 64'd0);
      bridge(1, 64'h55, 2'b00, 4'd1);
      req_valid = '0;
      repeat (3) step();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
